fc_layer_engine: RTL and testbench

//  Parametrised fully-connected layer engine; successor to the fixed 16-bit FC core. Consumes one

---
 rtl/fc_layer_engine_if.sv | 26 ++
 rtl/fc_layer_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_fc_layer_engine.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fc_layer_engine_if.sv
`default_nettype none
// ============================================================================
// fc_layer_engine_if : input/output stream bundle for the FC layer engine
// Revision: 1.0
// ============================================================================
interface fc_layer_engine_if #(
  parameter int DATA_W = 16
) ();
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_data;

  modport master (
    output din_valid, din_data, dout_ready,
    input  din_ready, dout_valid, dout_data
  );

  modport slave (
    input  din_valid, din_data, dout_ready,
    output din_ready, dout_valid, dout_data
  );
endinterface
`default_nettype wire

// File: rtl/fc_layer_engine.sv
`default_nettype none
// ============================================================================
// fc_layer_engine : streaming fully-connected layer, fixed-point MAC with
//                   optional bias, ReLU and output saturation
// Revision: 1.0
// ============================================================================
module fc_layer_engine #(
  parameter  int DATA_W    = 16,
  parameter  int FRAC_BITS = 10,
  parameter  int ACC_W     = 32,
  parameter  int MAX_CIN   = 1024,
  parameter  int MAX_COUT  = 1024,
  localparam int CIN_W     = $clog2(MAX_CIN + 1),
  localparam int COUT_W    = $clog2(MAX_COUT + 1)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic [CIN_W-1:0]  cin,
  input  wire logic [COUT_W-1:0] cout,
  input  wire logic              has_bias,
  input  wire logic              act_mode,
  output logic                   busy,
  output logic                   done,
  fc_layer_engine_if.slave       s
);

  localparam int XA_W = $clog2(MAX_CIN);
  localparam int YA_W = $clog2(MAX_COUT);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IN = 3'd1,
    S_MAC     = 3'd2,
    S_BIAS    = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [CIN_W-1:0]         cin_q, cin_d;
  logic [COUT_W-1:0]        cout_q, cout_d;
  logic                     has_bias_q, has_bias_d;
  logic                     act_q, act_d;
  logic [CIN_W-1:0]         i_q, i_d;
  logic [COUT_W-1:0]        o_q, o_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     din_ready_q, din_ready_d;
  logic                     dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0]        dout_data_q, dout_data_d;

  logic [DATA_W-1:0]        x_mem [MAX_CIN];
  logic signed [ACC_W-1:0]  y_mem [MAX_COUT];

  logic                     din_beat, dout_beat, i_last, o_last;
  logic signed [DATA_W-1:0] x_rd;
  logic signed [2*DATA_W-1:0] prod_full, prod_sh;
  logic signed [ACC_W-1:0]  prod, y_cur, y_rd;
  logic                     x_wr_en, y_wr_en;
  logic [COUT_W-1:0]        y_wr_idx;
  logic signed [ACC_W-1:0]  y_wr_val;

  function automatic logic [DATA_W-1:0] sat_act(input logic signed [ACC_W-1:0] v,
                                                 input logic relu);
    logic signed [ACC_W-1:0] a;
    a = (relu && v < 0) ? '0 : v;
    if (a > SAT_MAX)      sat_act = SAT_MAX[DATA_W-1:0];
    else if (a < SAT_MIN) sat_act = SAT_MIN[DATA_W-1:0];
    else                  sat_act = a[DATA_W-1:0];
  endfunction

  always_comb begin
    din_beat  = s.din_valid & din_ready_q;
    dout_beat = dout_valid_q & s.dout_ready;
    i_last    = (i_q == cin_q - 1'b1);
    o_last    = (o_q == cout_q - 1'b1);
    x_rd      = $signed(x_mem[i_q[XA_W-1:0]]);
    prod_full = x_rd * $signed(s.din_data);
    // Arithmetic shift floors toward -inf, matching the fixed-point rescale.
    prod_sh   = prod_full >>> FRAC_BITS;
    prod      = ACC_W'(prod_sh);
    y_cur     = y_mem[o_q[YA_W-1:0]];

    state_d    = state_q;
    cin_d      = cin_q;
    cout_d     = cout_q;
    has_bias_d = has_bias_q;
    act_d      = act_q;
    i_d        = i_q;
    o_d        = o_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    x_wr_en    = 1'b0;
    y_wr_en    = 1'b0;
    y_wr_idx   = o_q;
    y_wr_val   = acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cin == '0 || cout == '0 || cin > CIN_W'(MAX_CIN) || cout > COUT_W'(MAX_COUT)) begin
            done_d = 1'b1;
          end else begin
            cin_d      = cin;
            cout_d     = cout;
            has_bias_d = has_bias;
            act_d      = act_mode;
            i_d        = '0;
            o_d        = '0;
            state_d    = S_LOAD_IN;
          end
        end
      end
      S_LOAD_IN: begin
        if (din_beat) begin
          x_wr_en = 1'b1;
          if (i_last) begin
            i_d     = '0;
            state_d = S_MAC;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        if (din_beat) begin
          acc_d = (i_q == '0) ? prod : acc_q + prod;
          if (i_last) begin
            y_wr_en  = 1'b1;
            y_wr_val = acc_d;
            i_d      = '0;
            if (o_last) begin
              o_d     = '0;
              state_d = has_bias_q ? S_BIAS : S_OUT;
            end else begin
              o_d = o_q + 1'b1;
            end
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_BIAS: begin
        if (din_beat) begin
          y_wr_en  = 1'b1;
          y_wr_val = y_cur + ACC_W'($signed(s.din_data));
          if (o_last) begin
            o_d     = '0;
            state_d = S_OUT;
          end else begin
            o_d = o_q + 1'b1;
          end
        end
      end
      S_OUT: begin
        if (dout_beat) begin
          if (o_last) begin
            o_d     = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            o_d = o_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    din_ready_d  = (state_d == S_LOAD_IN) || (state_d == S_MAC) || (state_d == S_BIAS);
    dout_valid_d = (state_d == S_OUT);

    // Bypass the y write of this cycle so the first output needs no extra cycle.
    y_rd = (y_wr_en && y_wr_idx == o_d) ? y_wr_val : y_mem[o_d[YA_W-1:0]];
    dout_data_d = dout_data_q;
    if (state_d == S_OUT && (state_q != S_OUT || dout_beat)) begin
      dout_data_d = sat_act(y_rd, act_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cin_q        <= '0;
      cout_q       <= '0;
      has_bias_q   <= 1'b0;
      act_q        <= 1'b0;
      i_q          <= '0;
      o_q          <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cin_q        <= cin_d;
      cout_q       <= cout_d;
      has_bias_q   <= has_bias_d;
      act_q        <= act_d;
      i_q          <= i_d;
      o_q          <= o_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (x_wr_en) x_mem[i_q[XA_W-1:0]] <= s.din_data;
    if (y_wr_en) y_mem[y_wr_idx[YA_W-1:0]] <= y_wr_val;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign s.din_ready  = din_ready_q;
  assign s.dout_valid = dout_valid_q;
  assign s.dout_data  = dout_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_engine.sv
`default_nettype none
// ============================================================================
// tb_fc_layer_engine : directed self-checking bench for fc_layer_engine
// Revision: 1.0
// ============================================================================
module tb_fc_layer_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] cin;
  logic [4:0] cout;
  logic       has_bias;
  logic       act_mode;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_err = 0;
  int stream[$];
  int exp_q[$];

  fc_layer_engine_if #(.DATA_W(16)) s_if ();

  fc_layer_engine #(
    .DATA_W   (16),
    .FRAC_BITS(10),
    .ACC_W    (32),
    .MAX_CIN  (16),
    .MAX_COUT (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cin     (cin),
    .cout    (cout),
    .has_bias(has_bias),
    .act_mode(act_mode),
    .busy    (busy),
    .done    (done),
    .s       (s_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Feeds the stream queue and collects outputs against exp_q.
  task automatic run_layer(input int n_in, input int n_out, input bit bias, input bit act,
                           input bit gaps, input bit stall, input string name);
    int k = 0;
    int o = 0;
    int stall_cnt = 0;
    int cyc = 0;
    bit stalled = 0;
    bit seen_done = 0;
    logic [15:0] held = '0;
    @(negedge clk);
    cin = 5'(n_in); cout = 5'(n_out); has_bias = bias; act_mode = act; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen_done && cyc < 3000) begin
      if (done) begin
        seen_done = 1;
      end else begin
        if (stalled) begin
          chk({name, "_hold_valid"}, 32'(s_if.dout_valid), 1);
          chk({name, "_hold_data"}, $signed(s_if.dout_data), $signed(held));
        end
        if (k < stream.size()) begin
          s_if.din_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
          s_if.din_data  = 16'(stream[k]);
          if (s_if.din_valid && s_if.din_ready) k++;
        end else begin
          s_if.din_valid = 1'b0;
        end
        if (s_if.dout_valid) begin
          s_if.dout_ready = !stall || (stall_cnt == 3);
          stalled = !s_if.dout_ready;
          held    = s_if.dout_data;
          if (s_if.dout_ready) begin
            if (o < exp_q.size())
              chk($sformatf("%s_out%0d", name, o), $signed(s_if.dout_data), exp_q[o]);
            o++;
            stall_cnt = 0;
          end else begin
            stall_cnt++;
          end
        end else begin
          s_if.dout_ready = 1'b0;
          stalled = 0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    s_if.din_valid  = 1'b0;
    s_if.dout_ready = 1'b0;
    chk({name, "_done_seen"}, 32'(seen_done), 1);
    chk({name, "_out_count"}, o, n_out);
    chk({name, "_in_count"}, k, stream.size());
    chk({name, "_busy_after"}, 32'(busy), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cin = '0; cout = '0; has_bias = 1'b0; act_mode = 1'b0;
    s_if.din_valid = 1'b0; s_if.din_data = '0; s_if.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_din_ready", 32'(s_if.din_ready), 0);
    chk("rst_dout_valid", 32'(s_if.dout_valid), 0);
    chk("rst_dout_data", 32'(s_if.dout_data), 0);
    rst = 1'b0;

    // 1.0*0.5 + 2.0*0.25 = 1.0
    stream = '{1024, 2048, 512, 256};
    exp_q  = '{1024};
    run_layer(2, 1, 0, 0, 0, 0, "basic");

    // -2.0+0.5 -> ReLU 0 ; 0.5+0.5 = 1.0
    stream = '{1024, -2048, 512, 512, 512};
    exp_q  = '{0, 1024};
    run_layer(1, 2, 1, 1, 0, 0, "bias_relu");

    stream = '{32767, 32767, -32768};
    exp_q  = '{32767, -32768};
    run_layer(1, 2, 0, 0, 0, 0, "sat");

    // y0 = 1024-1024+1024-3072 = -2048 ; y1 = -100-2+14+100 = 12 (floor on -1.5)
    stream = '{1024, -512, 2048, 1024, 2048, 512, -100, 3, 7, -3072, 100};
    exp_q  = '{-2048, 12};
    run_layer(3, 2, 1, 0, 1, 1, "bp");

    // Abort mid-MAC with a one-cycle reset.
    @(negedge clk);
    cin = 5'd2; cout = 5'd2; has_bias = 1'b0; act_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_if.din_valid = 1'b1; s_if.din_data = 16'd1024;
    @(negedge clk);
    s_if.din_data = 16'd2048;
    @(negedge clk);
    s_if.din_data = 16'd512;
    @(negedge clk);
    s_if.din_valid = 1'b0;
    chk("mac_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_dout_valid", 32'(s_if.dout_valid), 0);
    chk("abort_din_ready", 32'(s_if.din_ready), 0);

    stream = '{1024, 2048, 512, 256};
    exp_q  = '{1024};
    run_layer(2, 1, 0, 0, 0, 0, "after_rst");

    // Zero and oversize dims finish immediately without taking data.
    @(negedge clk);
    cin = 5'd0; cout = 5'd1; start = 1'b1; s_if.din_valid = 1'b1; s_if.din_data = 16'd7;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_din_ready", 32'(s_if.din_ready), 0);
    @(negedge clk);
    chk("zero_done_clr", 32'(done), 0);
    chk("zero_busy2", 32'(busy), 0);
    cin = 5'd17; cout = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_if.din_valid = 1'b0;
    chk("over_done", 32'(done), 1);
    chk("over_busy", 32'(busy), 0);

    stream = '{-1024, 3072, 1024, 1024};
    exp_q  = '{2048};
    run_layer(2, 1, 0, 0, 0, 0, "post_zero");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
